// File: rtl/lab3_pkg.sv
// -----------------------------------------------------------------------------
// lab3_pkg
// Shared constants for the Lab3 detection-capture slice.
//   LAB3_WIN    : history window width in bits (newest bit in bit 0)
//   LAB3_DEPTH  : capture FIFO depth (power of two)
//   LAB3_CNT_W  : detection counter width
//   lab3_lvl_w(): width of a 0..DEPTH occupancy count
// -----------------------------------------------------------------------------
package lab3_pkg;

  localparam int unsigned LAB3_WIN   = 4;
  localparam int unsigned LAB3_DEPTH = 4;
  localparam int unsigned LAB3_CNT_W = 8;

  // An occupancy count must reach DEPTH itself, hence one bit beyond the
  // pointer width.
  function automatic int unsigned lab3_lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lab3_detect_capture_if.sv
// -----------------------------------------------------------------------------
// lab3_detect_capture_if
// Bundles the detector-side inputs and the capture/read-side outputs of
// lab3_detect_capture.
//   master : drives x, z, rd_en; observes dout, empty, full, level,
//            det_count, overflow (testbench / upstream logic)
//   slave  : the capture block itself
// -----------------------------------------------------------------------------
interface lab3_detect_capture_if
  import lab3_pkg::*;
#(
  parameter int unsigned WIN   = LAB3_WIN,
  parameter int unsigned DEPTH = LAB3_DEPTH,
  parameter int unsigned CNT_W = LAB3_CNT_W
);

  logic                           x;
  logic                           z;
  logic                           rd_en;
  logic [WIN-1:0]                 dout;
  logic                           empty;
  logic                           full;
  logic [lab3_lvl_w(DEPTH)-1:0]   level;
  logic [CNT_W-1:0]               det_count;
  logic                           overflow;

  modport master (
    output x, z, rd_en,
    input  dout, empty, full, level, det_count, overflow
  );

  modport slave (
    input  x, z, rd_en,
    output dout, empty, full, level, det_count, overflow
  );

endinterface

// File: rtl/lab3_sync_fifo.sv
// -----------------------------------------------------------------------------
// lab3_sync_fifo
// Single-clock first-word-fall-through FIFO with a sticky overflow flag.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-low
//   push     : write request for din
//   pop      : read request for the head entry (ignored while empty)
//   din      : write data
//   dout     : head entry, 0 while empty
//   empty    : no entries stored (registered)
//   full     : DEPTH entries stored (registered)
//   level    : number of entries stored (registered)
//   overflow : sticky, set when a push is dropped because the FIFO is full
// A push while full is still accepted when a pop frees the head slot on the
// same edge. A pop while empty never cancels a concurrent push.
// -----------------------------------------------------------------------------
module lab3_sync_fifo
  import lab3_pkg::*;
#(
  parameter  int unsigned W     = LAB3_WIN,
  parameter  int unsigned DEPTH = LAB3_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = lab3_lvl_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          empty_q;
  logic          full_q;
  logic          overflow_q;
  logic          pop_ok;
  logic          push_ok;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      level_q <= level_d;
      // Flags are derived from the next level so they stay registered yet
      // always agree with level after the edge.
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LW'(DEPTH));
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because dout is forced to zero while empty, and leaving it unreset lets
  // it map onto plain flops or RAM without a reset tree.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout     = empty_q ? '0 : mem[rd_ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/lab3_detect_capture.sv
// -----------------------------------------------------------------------------
// lab3_detect_capture
// Downstream stage of the Lab3 Mealy sequence detector. Keeps a sliding
// window of the last WIN bits of x and, on every edge where z=1, captures
// that window (current x included) into a small FWFT FIFO. Counts every
// detection and lets a reader drain captured windows with rd_en.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : lab3_detect_capture_if.slave
//           in : x, z, rd_en
//           out: dout (bit 0 newest x, bit WIN-1 oldest), empty, full,
//                level, det_count (wraps), overflow (sticky)
// -----------------------------------------------------------------------------
module lab3_detect_capture
  import lab3_pkg::*;
#(
  parameter  int unsigned WIN   = LAB3_WIN,
  parameter  int unsigned DEPTH = LAB3_DEPTH,
  parameter  int unsigned CNT_W = LAB3_CNT_W,
  localparam int unsigned LW    = lab3_lvl_w(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  lab3_detect_capture_if.slave bus
);

  // Only the WIN-1 most recent past bits are ever used to build a window,
  // so the oldest history bit is not stored.
  logic [WIN-2:0]  hist_q;
  logic [WIN-1:0]  win;
  logic [CNT_W-1:0] det_count_q;
  logic            pop_req;

  logic [WIN-1:0]  fifo_dout;
  logic            fifo_empty;
  logic            fifo_full;
  logic [LW-1:0]   fifo_level;
  logic            fifo_overflow;

  // Window as it will stand after this edge: past bits shifted up, current x
  // in bit 0.
  assign win = {hist_q, bus.x};

  // A read request against an empty FIFO is discarded here so it can never
  // interact with a concurrent capture.
  assign pop_req = bus.rd_en & ~fifo_empty;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q      <= '0;
      det_count_q <= '0;
    end else begin
      hist_q <= win[WIN-2:0];
      // Counts every detection, including ones the FIFO drops; wraps silently.
      if (bus.z) det_count_q <= det_count_q + CNT_W'(1);
    end
  end

  lab3_sync_fifo #(
    .W     (WIN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (bus.z),
    .pop      (pop_req),
    .din      (win),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level),
    .overflow (fifo_overflow)
  );

  assign bus.dout      = fifo_dout;
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.level     = fifo_level;
  assign bus.det_count = det_count_q;
  assign bus.overflow  = fifo_overflow;

endmodule

// File: tb/tb_lab3_detect_capture.sv
// -----------------------------------------------------------------------------
// tb_lab3_detect_capture
// Directed scenarios plus randomized traffic on x, z, rd_en and reset,
// checked every falling edge against a queue-based reference model, with
// hand-computed literal expectations at key points of the directed part.
// -----------------------------------------------------------------------------
module tb_lab3_detect_capture;
  import lab3_pkg::*;

  localparam int WIN   = LAB3_WIN;
  localparam int DEPTH = LAB3_DEPTH;
  localparam int CNT_W = LAB3_CNT_W;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  lab3_detect_capture_if #(.WIN(WIN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  lab3_detect_capture #(.WIN(WIN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is a queue of windows, history is a queue of
  // past x bits, counter is an integer taken modulo 2^CNT_W.
  // ---------------------------------------------------------------------------
  logic [WIN-1:0] m_q[$];
  bit             m_hist[$];
  int             m_cnt = 0;
  bit             m_ovf = 1'b0;
  logic [WIN-1:0] m_win;
  bit             m_pop_ok;
  bit             m_was_full;

  function automatic logic [WIN-1:0] model_window(input bit xi);
    logic [WIN-1:0] w;
    w    = '0;
    w[0] = xi;
    for (int i = 1; i < WIN; i++)
      if (m_hist.size() >= i) w[i] = m_hist[m_hist.size() - i];
    return w;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_hist.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      m_win      = model_window(bus.x);
      m_was_full = (m_q.size() == DEPTH);
      m_pop_ok   = bus.rd_en && (m_q.size() != 0);
      if (m_pop_ok) void'(m_q.pop_front());
      if (bus.z) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (!m_was_full || m_pop_ok) m_q.push_back(m_win);
        else                         m_ovf = 1'b1;
      end
      m_hist.push_back(bus.x);
      if (m_hist.size() > WIN) void'(m_hist.pop_front());
    end
  end

  // Compare process: every falling edge, DUT against model.
  always @(negedge clock) begin
    check("dout",      32'(bus.dout),      (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("empty",     32'(bus.empty),     32'(m_q.size() == 0));
    check("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
    check("level",     32'(bus.level),     32'(m_q.size()));
    check("det_count", 32'(bus.det_count), 32'(m_cnt));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit xi, input bit zi, input bit ri);
    bus.x     = xi;
    bus.z     = zi;
    bus.rd_en = ri;
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    bus.x     = 1'b0;
    bus.z     = 1'b0;
    bus.rd_en = 1'b0;
    reset     = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"},    32'(bus.empty),     32'd1);
    check({tag, "_full"},     32'(bus.full),      32'd0);
    check({tag, "_level"},    32'(bus.level),     32'd0);
    check({tag, "_dout"},     32'(bus.dout),      32'd0);
    check({tag, "_det"},      32'(bus.det_count), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow),  32'd0);
  endtask

  initial begin
    bus.x     = 1'b0;
    bus.z     = 1'b0;
    bus.rd_en = 1'b0;

    // Reset held low across several edges.
    repeat (3) @(posedge clock);
    #2;
    check_reset_values("rst");
    reset = 1'b1;

    // Capture: x=1,0,1,1 with z only on the fourth edge.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("cap_dout",  32'(bus.dout),      32'b1011);
    check("cap_level", 32'(bus.level),     32'd1);
    check("cap_det",   32'(bus.det_count), 32'd1);

    // Drain, then a read while empty.
    drive(1'b0, 1'b0, 1'b1);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_dout",  32'(bus.dout),  32'd0);
    check("drain_level", 32'(bus.level), 32'd0);
    drive(1'b0, 1'b0, 1'b1);
    check("idle_rd_level", 32'(bus.level),     32'd0);
    check("idle_rd_det",   32'(bus.det_count), 32'd1);

    // Overflow: six detections, x=1,1,0,1,0,0, no reads.
    // Windows: 0001, 0011, 0110, 1101, (1010 dropped), (0100 dropped).
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("ovf_full4", 32'(bus.full),     32'd1);
    check("ovf_flag4", 32'(bus.overflow), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    check("ovf_flag5", 32'(bus.overflow), 32'd1);
    drive(1'b0, 1'b1, 1'b0);
    check("ovf_level", 32'(bus.level),     32'd4);
    check("ovf_det",   32'(bus.det_count), 32'd6);
    check("ovf_pop0",  32'(bus.dout),      32'b0001);
    drive(1'b0, 1'b0, 1'b1);
    check("ovf_pop1",  32'(bus.dout),      32'b0011);
    drive(1'b0, 1'b0, 1'b1);
    check("ovf_pop2",  32'(bus.dout),      32'b0110);
    drive(1'b0, 1'b0, 1'b1);
    check("ovf_pop3",  32'(bus.dout),      32'b1101);
    drive(1'b0, 1'b0, 1'b1);
    check("ovf_drained", 32'(bus.empty),   32'd1);
    check("ovf_sticky",  32'(bus.overflow), 32'd1);

    // Full with simultaneous push and pop.
    // Fill with x=1,0,0,1 -> 0001, 0010, 0100, 1001; then x=1 -> 0011 appended.
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("pp_level", 32'(bus.level),    32'd4);
    check("pp_ovf",   32'(bus.overflow), 32'd0);
    check("pp_dout",  32'(bus.dout),     32'b0010);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("pp_dout2", 32'(bus.dout),     32'b1001);
    drive(1'b0, 1'b0, 1'b1);
    check("pp_newest", 32'(bus.dout),    32'b0011);

    // Asynchronous reset between edges with three entries stored.
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("ar_level3", 32'(bus.level), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("ar");
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Counter wrap: 256 detections with reads enabled.
    for (int i = 0; i < 256; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      if (i == 254) check("wrap_255", 32'(bus.det_count), 32'd255);
    end
    check("wrap_0",     32'(bus.det_count), 32'd0);
    check("wrap_noovf", 32'(bus.overflow),  32'd0);

    // Randomized traffic with varying read pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      case ((i / 500) % 3)
        0:       rd_pct = 20;
        1:       rd_pct = 50;
        default: rd_pct = 85;
      endcase
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < rd_pct));
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
